// File: rtl/unidade_controle_multiciclo.sv
// Multicycle MIPS main control FSM plus ALU decoder.
// Moore outputs are decoded from the state register; PCEn and ALUControl also use Zero and Funct.
module unidade_controle_multiciclo #(
   parameter int SUPPORT_J   = 1,
   parameter int SUPPORT_SLT = 1
) (
   input  logic       ck,
   input  logic       reset_uc,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       Zero,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSrc,
   output logic [2:0] ALUControl,
   output logic       PCEn,
   output logic       op_invalido,
   output logic [3:0] estado
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTE  = 4'd6,
      ALUWB    = 4'd7,
      BRANCH   = 4'd8,
      ADDIEX   = 4'd9,
      ADDIWB   = 4'd10,
      JUMP     = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   state_t     state;
   state_t     next_state;
   state_t     out_state;
   logic [1:0] alu_op;
   logic       pc_write;
   logic       branch;
   logic       op_valido;

   assign op_valido = (Op == OP_LW) || (Op == OP_SW) || (Op == OP_RTYPE) ||
                      (Op == OP_BEQ) || (Op == OP_ADDI) ||
                      ((Op == OP_J) && (SUPPORT_J != 0));

   assign estado = state;

   always_ff @(posedge ck) begin
      if (!reset_uc)
         state <= FETCH;
      else
         state <= next_state;
   end

   // While reset is held the outputs show FETCH, with every side-effecting strobe gated off
   always_comb begin
      next_state  = FETCH;
      out_state   = reset_uc ? state : FETCH;
      IorD        = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      PCSrc       = 2'b00;
      PCEn        = 1'b0;
      op_invalido = 1'b0;
      alu_op      = 2'b00;
      pc_write    = 1'b0;
      branch      = 1'b0;

      case (state)
         FETCH:    next_state = DECODE;
         DECODE: begin
            case (Op)
               OP_LW, OP_SW: next_state = MEMADR;
               OP_RTYPE:     next_state = EXECUTE;
               OP_BEQ:       next_state = BRANCH;
               OP_ADDI:      next_state = ADDIEX;
               OP_J:         next_state = (SUPPORT_J != 0) ? JUMP : FETCH;
               default:      next_state = FETCH;
            endcase
         end
         MEMADR:   next_state = (Op == OP_SW) ? MEMWRITE : MEMREAD;
         MEMREAD:  next_state = MEMWB;
         EXECUTE:  next_state = ALUWB;
         ADDIEX:   next_state = ADDIWB;
         default:  next_state = FETCH;
      endcase

      case (out_state)
         FETCH: begin
            IRWrite  = 1'b1;
            ALUSrcB  = 2'b01;
            pc_write = 1'b1;
         end
         DECODE: begin
            ALUSrcB     = 2'b11;
            op_invalido = !op_valido;
         end
         MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         MEMREAD:  IorD = 1'b1;
         MEMWB: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
         end
         MEMWRITE: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
         end
         EXECUTE: begin
            ALUSrcA = 1'b1;
            alu_op  = 2'b10;
         end
         ALUWB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
         end
         BRANCH: begin
            ALUSrcA = 1'b1;
            alu_op  = 2'b01;
            PCSrc   = 2'b01;
            branch  = 1'b1;
         end
         ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         ADDIWB:   RegWrite = 1'b1;
         JUMP: begin
            PCSrc    = 2'b10;
            pc_write = 1'b1;
         end
         default: ;
      endcase

      PCEn = pc_write | (branch & Zero);

      if (!reset_uc) begin
         IRWrite     = 1'b0;
         PCEn        = 1'b0;
         RegWrite    = 1'b0;
         MemWrite    = 1'b0;
         op_invalido = 1'b0;
      end
   end

   // ALUOp 11 is never produced here but still maps to add
   always_comb begin
      ALUControl = ALU_ADD;
      case (alu_op)
         2'b01: ALUControl = ALU_SUB;
         2'b10: begin
            case (Funct)
               F_ADD:   ALUControl = ALU_ADD;
               F_SUB:   ALUControl = ALU_SUB;
               F_AND:   ALUControl = ALU_AND;
               F_OR:    ALUControl = ALU_OR;
               F_SLT:   ALUControl = (SUPPORT_SLT != 0) ? ALU_SLT : ALU_ADD;
               default: ALUControl = ALU_ADD;
            endcase
         end
         default: ALUControl = ALU_ADD;
      endcase
   end

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Self-checking bench for unidade_controle_multiciclo: instruction-level model checked every
// cycle, plus literal state-sequence, ALU-code and register-write-count expectations.
module tb_unidade_controle_multiciclo;

   logic       ck = 1'b0;
   logic       reset_uc;
   logic [5:0] Op;
   logic [5:0] Funct;
   logic       Zero;
   logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, PCSrc;
   logic [2:0] ALUControl;
   logic       PCEn, op_invalido;
   logic [3:0] estado;

   int total = 0;
   int bad   = 0;

   localparam int K_LW   = 0;
   localparam int K_SW   = 1;
   localparam int K_R    = 2;
   localparam int K_BEQ  = 3;
   localparam int K_ADDI = 4;
   localparam int K_J    = 5;
   localparam int K_ILL  = 6;

   int step  = 0;
   bit known = 1'b0;

   always #5 ck = ~ck;

   unidade_controle_multiciclo dut (
      .ck          (ck),
      .reset_uc    (reset_uc),
      .Op          (Op),
      .Funct       (Funct),
      .Zero        (Zero),
      .IorD        (IorD),
      .MemWrite    (MemWrite),
      .IRWrite     (IRWrite),
      .RegDst      (RegDst),
      .MemtoReg    (MemtoReg),
      .RegWrite    (RegWrite),
      .ALUSrcA     (ALUSrcA),
      .ALUSrcB     (ALUSrcB),
      .PCSrc       (PCSrc),
      .ALUControl  (ALUControl),
      .PCEn        (PCEn),
      .op_invalido (op_invalido),
      .estado      (estado)
   );

   function automatic int kindOf(input logic [5:0] op);
      case (op)
         6'b100011: return K_LW;
         6'b101011: return K_SW;
         6'b000000: return K_R;
         6'b000100: return K_BEQ;
         6'b001000: return K_ADDI;
         6'b000010: return K_J;
         default:   return K_ILL;
      endcase
   endfunction

   // State codes visited by each instruction kind, one nibble per cycle starting at FETCH
   function automatic logic [31:0] pathWord(input int k);
      case (k)
         K_LW:    return 32'h0004_3210;
         K_SW:    return 32'h0000_5210;
         K_R:     return 32'h0000_7610;
         K_BEQ:   return 32'h0000_0810;
         K_ADDI:  return 32'h0000_A910;
         K_J:     return 32'h0000_0B10;
         default: return 32'h0000_0010;
      endcase
   endfunction

   function automatic int pathLen(input int k);
      case (k)
         K_LW:    return 5;
         K_SW:    return 4;
         K_R:     return 4;
         K_BEQ:   return 3;
         K_ADDI:  return 4;
         K_J:     return 3;
         default: return 2;
      endcase
   endfunction

   function automatic logic [2:0] functCode(input logic [5:0] f);
      case (f)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge ck) begin
      if (!reset_uc) begin
         step  = 0;
         known = 1'b1;
      end else if (known) begin
         if (step >= pathLen(kindOf(Op)) - 1)
            step = 0;
         else
            step = step + 1;
      end
   end

   // Expected outputs follow from instruction kind and cycle index within that instruction
   always @(negedge ck) begin : compare
      int         k;
      bit         fe, de, ex, last;
      logic [31:0] w;
      logic       eIorD, eMemWrite, eIRWrite, eRegDst, eMemtoReg, eRegWrite, eALUSrcA;
      logic       ePCEn, eInv;
      logic [1:0] eALUSrcB, ePCSrc;
      logic [2:0] eALU;
      logic [3:0] eEst;
      if (known) begin
         k    = kindOf(Op);
         w    = pathWord(k);
         fe   = (step == 0);
         de   = (step == 1);
         ex   = (step == 2);
         last = (step == pathLen(k) - 1);
         eEst = w[4*step +: 4];
         if (reset_uc) begin
            eIRWrite  = fe;
            ePCEn     = fe || (ex && k == K_J) || (ex && k == K_BEQ && Zero);
            eRegWrite = last && (k == K_LW || k == K_R || k == K_ADDI);
            eMemWrite = (k == K_SW) && (step == 3);
            eIorD     = (k == K_LW || k == K_SW) && (step == 3);
            eRegDst   = (k == K_R) && (step == 3);
            eMemtoReg = (k == K_LW) && (step == 4);
            eALUSrcA  = ex && (k != K_J);
            eALUSrcB  = fe ? 2'b01 : de ? 2'b11 :
                        (ex && (k == K_LW || k == K_SW || k == K_ADDI)) ? 2'b10 : 2'b00;
            ePCSrc    = (ex && k == K_BEQ) ? 2'b01 : (ex && k == K_J) ? 2'b10 : 2'b00;
            eALU      = (ex && k == K_R) ? functCode(Funct) :
                        (ex && k == K_BEQ) ? 3'b110 : 3'b010;
            eInv      = de && (k == K_ILL);
         end else begin
            eIRWrite  = 1'b0;
            ePCEn     = 1'b0;
            eRegWrite = 1'b0;
            eMemWrite = 1'b0;
            eIorD     = 1'b0;
            eRegDst   = 1'b0;
            eMemtoReg = 1'b0;
            eALUSrcA  = 1'b0;
            eALUSrcB  = 2'b01;
            ePCSrc    = 2'b00;
            eALU      = 3'b010;
            eInv      = 1'b0;
         end
         checkOutput("estado", estado, eEst);
         checkOutput("IorD", IorD, eIorD);
         checkOutput("MemWrite", MemWrite, eMemWrite);
         checkOutput("IRWrite", IRWrite, eIRWrite);
         checkOutput("RegDst", RegDst, eRegDst);
         checkOutput("MemtoReg", MemtoReg, eMemtoReg);
         checkOutput("RegWrite", RegWrite, eRegWrite);
         checkOutput("ALUSrcA", ALUSrcA, eALUSrcA);
         checkOutput("ALUSrcB", ALUSrcB, eALUSrcB);
         checkOutput("PCSrc", PCSrc, ePCSrc);
         checkOutput("ALUControl", ALUControl, eALU);
         checkOutput("PCEn", PCEn, ePCEn);
         checkOutput("op_invalido", op_invalido, eInv);
      end
   end

   // Called at the start of a FETCH cycle; runs len cycles and pins the literal expectations
   task automatic applyStimulus(input string name, input logic [5:0] op, input logic [5:0] funct,
                                input logic zero, input logic [31:0] seq, input int len,
                                input int aluStep, input logic [2:0] aluExp, input int expWrites);
      int writes;
      writes   = 0;
      Op       = op;
      Funct    = funct;
      Zero     = zero;
      reset_uc = 1'b1;
      for (int i = 0; i < len; i++) begin
         @(negedge ck); #2;
         checkOutput({name, "_estado"}, estado, seq[4*i +: 4]);
         if (i == aluStep)
            checkOutput({name, "_alu"}, ALUControl, aluExp);
         if (RegWrite === 1'b1)
            writes++;
         @(posedge ck); #1;
      end
      checkOutput({name, "_writes"}, writes, expWrites);
   endtask

   initial begin
      int abortWrites;
      reset_uc = 1'b0;
      Op       = 6'b000000;
      Funct    = 6'b000000;
      Zero     = 1'b0;

      repeat (3) @(posedge ck);
      #1;
      @(negedge ck); #2;
      checkOutput("rst_estado", estado, 4'd0);
      checkOutput("rst_PCEn", PCEn, 1'b0);
      checkOutput("rst_IRWrite", IRWrite, 1'b0);

      @(posedge ck); #1;
      reset_uc = 1'b1;
      Op       = 6'b100011;
      @(negedge ck); #2;
      checkOutput("post_IRWrite", IRWrite, 1'b1);
      checkOutput("post_PCEn", PCEn, 1'b1);
      checkOutput("post_ALUSrcB", ALUSrcB, 2'b01);
      checkOutput("post_ALU", ALUControl, 3'b010);
      @(posedge ck); #1;
      applyStimulus("lw_tail", 6'b100011, 6'b000000, 1'b0, 32'h4321, 4, 1, 3'b010, 1);

      applyStimulus("lw",    6'b100011, 6'b000000, 1'b0, 32'h43210, 5, 2, 3'b010, 1);
      applyStimulus("r_sub", 6'b000000, 6'b100010, 1'b0, 32'h7610, 4, 2, 3'b110, 1);
      applyStimulus("r_slt", 6'b000000, 6'b101010, 1'b0, 32'h7610, 4, 2, 3'b111, 1);
      applyStimulus("r_unk", 6'b000000, 6'b111111, 1'b0, 32'h7610, 4, 2, 3'b010, 1);
      applyStimulus("r_and", 6'b000000, 6'b100100, 1'b1, 32'h7610, 4, 2, 3'b000, 1);
      applyStimulus("r_or",  6'b000000, 6'b100101, 1'b0, 32'h7610, 4, 2, 3'b001, 1);
      applyStimulus("r_add", 6'b000000, 6'b100000, 1'b0, 32'h7610, 4, 2, 3'b010, 1);
      applyStimulus("beq_t", 6'b000100, 6'b000000, 1'b1, 32'h810, 3, 2, 3'b110, 0);
      applyStimulus("beq_n", 6'b000100, 6'b000000, 1'b0, 32'h810, 3, 2, 3'b110, 0);
      applyStimulus("sw",    6'b101011, 6'b000000, 1'b0, 32'h5210, 4, 1, 3'b010, 0);
      applyStimulus("j",     6'b000010, 6'b000000, 1'b0, 32'hB10, 3, 2, 3'b010, 0);
      applyStimulus("addi",  6'b001000, 6'b000000, 1'b0, 32'hA910, 4, 2, 3'b010, 1);
      applyStimulus("ill",   6'b111111, 6'b000000, 1'b0, 32'h10, 2, 1, 3'b010, 0);

      // Abort an R-type in EXECUTE: reset lands before ALUWB, so no write may follow
      abortWrites = 0;
      Op       = 6'b000000;
      Funct    = 6'b100010;
      Zero     = 1'b0;
      reset_uc = 1'b1;
      repeat (2) @(posedge ck);
      #1;
      @(negedge ck); #2;
      checkOutput("abort_exec", estado, 4'd6);
      reset_uc = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge ck); #1;
         @(negedge ck); #2;
         checkOutput("abort_estado", estado, 4'd0);
         if (RegWrite === 1'b1)
            abortWrites++;
      end
      checkOutput("abort_writes", abortWrites, 0);
      @(posedge ck); #1;
      applyStimulus("recover", 6'b001000, 6'b000000, 1'b0, 32'hA910, 4, 2, 3'b010, 1);

      @(negedge ck);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/unidade_controle_multiciclo.md
Name: unidade_controle_multiciclo

Overview:
- Multicycle MIPS main control FSM plus ALU decoder.
- Sits directly upstream of bancoRegistradores: generates its write enable (WE3 = RegWrite), write-address select (RegDst) and write-data select (MemtoReg).
- Also drives PC, IR, memory and ALU datapath controls from Op/Funct of the latched instruction and the ALU Zero flag.

Parameters:
- SUPPORT_J, 1: if 0, opcode j (000010) is treated as illegal.
- SUPPORT_SLT, 1: if 0, funct slt (101010) is treated as an unknown funct.

Ports:
- ck  in  1  clock, rising edge
- reset_uc  in  1  synchronous, active-low reset
- Op  in  6  instruction[31:26] from IR
- Funct  in  6  instruction[5:0] from IR
- Zero  in  1  ALU zero flag
- IorD  out  1  memory address select (0=PC, 1=ALUOut)
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction register load
- RegDst  out  1  A3 select (0=rt, 1=rd)
- MemtoReg  out  1  WD3 select (0=ALUOut, 1=Data)
- RegWrite  out  1  to WE3 of bancoRegistradores
- ALUSrcA  out  1  0=PC, 1=RD1 register
- ALUSrcB  out  2  00=RD2, 01=const 4, 10=SignImm, 11=SignImm<<2
- PCSrc  out  2  00=ALUResult, 01=ALUOut, 10=jump target
- ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- PCEn  out  1  PCWrite | (Branch & Zero)
- op_invalido  out  1  one-cycle pulse: illegal opcode seen in DECODE
- estado  out  4  current state code (debug)

Behaviour:
- Moore FSM. 4-bit state register updates on rising ck. Outputs are decoded combinationally from the state; PCEn and ALUControl also depend on Zero and Funct.
- Reset: when reset_uc=0 at a rising edge, state <= FETCH (0).
  - While reset_uc=0, IRWrite, PCEn, RegWrite, MemWrite and op_invalido are forced to 0 combinationally.
  - All other outputs show the FETCH values.
- Reset mid-instruction aborts that instruction. No partial register write occurs after the reset edge.
- Unlisted outputs are 0 in every state.
- State codes, outputs and transitions:
  - 0 FETCH: IRWrite=1, ALUSrcB=01, ALUOp=00, PCWrite=1 -> DECODE.
  - 1 DECODE: ALUSrcB=11, ALUOp=00. Next state by Op:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) -> EXECUTE
    - 000100 (beq) -> BRANCH
    - 001000 (addi) -> ADDIEX
    - 000010 (j) -> JUMP
    - any other Op -> FETCH, with op_invalido=1 in this state.
  - 2 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> MEMREAD if lw, MEMWRITE if sw.
  - 3 MEMREAD: IorD=1 -> MEMWB.
  - 4 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
  - 5 MEMWRITE: IorD=1, MemWrite=1 -> FETCH.
  - 6 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
  - 7 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
  - 8 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1 -> FETCH.
  - 9 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB.
  - 10 ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
  - 11 JUMP: PCSrc=10, PCWrite=1 -> FETCH.
  - 12-15: all outputs 0 -> FETCH.
- ALU decoder (ALUOp is internal, 2 bits):
  - ALUOp 00 -> 010; ALUOp 01 -> 110.
  - ALUOp 10, decoded by Funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Any other Funct -> 010.
  - ALUOp 11 -> 010.
- Instruction latency in cycles, counted from entry to FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- RegWrite is high for exactly one cycle per register-writing instruction, and only in the final state of that instruction.
- Op and Funct are sampled only from DECODE onward. The IR is stable from then on because IRWrite=1 only in FETCH.

Test Plan:
- Hold reset_uc=0 for 3 edges, then release -> estado=0 and PCEn=0/IRWrite=0 during reset; first post-reset cycle shows IRWrite=1, PCEn=1, ALUSrcB=01, ALUControl=010.
- Op=100011 (lw) -> estado sequence 0,1,2,3,4,0; in state 4, RegWrite=1, MemtoReg=1, RegDst=0; IorD=1 in state 3.
- Op=000000 with Funct 100010, then 101010 -> ALUControl=110, then 111 in EXECUTE; state 7 has RegWrite=1, RegDst=1. Funct=111111 -> 010.
- Op=000100 (beq) with Zero=1 -> PCEn=1, PCSrc=01, ALUControl=110 in state 8. Repeat with Zero=0 -> PCEn=0. Both take 3 cycles and write no register.
- Op=101011 (sw) -> sequence 0,1,2,5,0 with MemWrite=1 only in state 5 and RegWrite=0 throughout. Op=000010 (j) -> 0,1,11,0 with PCSrc=10, PCEn=1.
- Op=111111 -> op_invalido=1 for one cycle in DECODE, then FETCH. Also drive reset_uc=0 while estado=6 -> next edge estado=0, and no RegWrite pulse occurs.
